mac_row_seq: RTL and testbench

- Sequencer for one mac_row: accepts a job (step count, activation base address), then drives mac_row's load/execute/a_select and the activation buffer read port.
- Sequence per job: psum preload, N accumulation steps with stall support, a drain window for mac_row's internal register delay, then a done pulse marking final_psum valid.
- Sits between the array-level controller and one mac_row plus its activation SRAM.

---
 rtl/mac_row_seq.sv | 180 ++++++++++++++++++
 tb/tb_mac_row_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mac_row_seq.sv
// Job sequencer for one mac_row: psum preload, stallable accumulation steps, drain window, done pulse.
// Optional stall performance counter is enabled with the MAC_ROW_SEQ_PERF_EN macro.
module mac_row_seq #(
    parameter int ADDR_W    = 8,
    parameter int CNT_W     = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_steps,
    input  logic [ADDR_W-1:0] act_base,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              load,
    output logic              execute,
    output logic              a_select,
    output logic              act_ren,
`ifdef MAC_ROW_SEQ_PERF_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [ADDR_W-1:0] act_addr
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRELOAD = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    step_q, step_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [3:0]          drain_q, drain_d;

    // Next-state logic for the job FSM and its counters.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        num_d   = num_q;
        base_d  = base_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_steps;
                    base_d  = act_base;
                    step_d  = {CNT_W{1'b0}};
                    state_d = S_PRELOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRELOAD: begin
                drain_d = 4'd0;
                if (num_q != {CNT_W{1'b0}}) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_RUN: begin
                // The last step is detected before incrementing, so a full-range job never overflows.
                if (stall) begin
                    state_d = S_RUN;
                end else begin
                    step_d = step_q + CNT_W'(1);
                    if (step_q == num_q - CNT_W'(1)) begin
                        drain_d = 4'd0;
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == 4'(DRAIN_CYC - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and job registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= {CNT_W{1'b0}};
            num_q   <= {CNT_W{1'b0}};
            base_q  <= {ADDR_W{1'b0}};
            drain_q <= 4'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            num_q   <= num_d;
            base_q  <= base_d;
            drain_q <= drain_d;
        end
    end

    // Output decode from registered state; stall only gates the RUN strobes.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        load     = 1'b0;
        execute  = 1'b0;
        a_select = 1'b0;
        act_ren  = 1'b0;
        act_addr = {ADDR_W{1'b0}};
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_PRELOAD: begin
                busy     = 1'b1;
                load     = 1'b1;
                execute  = 1'b1;
                act_ren  = 1'b1;
                act_addr = base_q;
            end
            S_RUN: begin
                busy     = 1'b1;
                execute  = ~stall;
                a_select = step_q[0];
                act_ren  = ~step_q[0] & ~stall;
                act_addr = base_q + ADDR_W'(step_q >> 1);
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

`ifdef MAC_ROW_SEQ_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled RUN cycles, restarted by each accepted job.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && start) begin
            stall_cnt_d = 16'h0000;
        end else if ((state_q == S_RUN) && stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mac_row_seq.sv
// Directed bench for mac_row_seq: per-cycle expected outputs go through a scoreboard queue.
module tb_mac_row_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] num_steps;
    logic [7:0] act_base;
    logic       stall;
    logic       busy, done, load, execute, a_select, act_ren;
    logic [7:0] act_addr;
`ifdef MAC_ROW_SEQ_PERF_EN
    logic [15:0] stall_cnt;
`endif

    typedef struct {
        logic [13:0] e;
        logic [13:0] m;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    localparam logic [13:0] FULL   = 14'h3FFF;
    localparam logic [13:0] NOADDR = 14'h3F00;

    mac_row_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_steps (num_steps),
        .act_base  (act_base),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .load      (load),
        .execute   (execute),
        .a_select  (a_select),
        .act_ren   (act_ren),
`ifdef MAC_ROW_SEQ_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .act_addr  (act_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] mk(input logic b, input logic d, input logic l,
                                       input logic x, input logic s, input logic r,
                                       input logic [7:0] a);
        return {b, d, l, x, s, r, a};
    endfunction

    // One clock cycle: drive inputs, queue the expectation, compare on the falling edge.
    task automatic tick(input logic st, input logic stl, input logic rst,
                        input logic [13:0] e, input logic [13:0] m, input string tag);
        exp_t        ent;
        logic [13:0] obs;
        start = st;
        stall = stl;
        reset = rst;
        exp_q.push_back('{e, m, tag});
        @(negedge clk);
        ent = exp_q.pop_front();
        obs = {busy, done, load, execute, a_select, act_ren, act_addr};
        n_checks++;
        assert ((obs & ent.m) === (ent.e & ent.m)) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (mask %h)", ent.tag, obs, ent.e, ent.m);
        end
        @(posedge clk);
        #1;
    endtask

    // Full job from the accepting IDLE cycle through DONE; start is held at sd after acceptance.
    task automatic job(input logic [7:0] base, input int n, input int stall_at,
                       input int stall_len, input logic sd);
        logic [7:0] a;
        num_steps = 8'(n);
        act_base  = base;
        tick(1'b1, 1'b0, 1'b0, 14'h0000, FULL, "accept");
        num_steps = 8'($urandom);
        act_base  = 8'($urandom);
        tick(sd, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, base), FULL, "preload");
        for (int i = 0; i < n; i++) begin
            a = base + 8'(i >> 1);
            if (i == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    tick(sd, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, i[0], 1'b0, a), FULL, "stall");
                end
            end
            tick(sd, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, i[0], ~i[0], a), FULL, "run");
        end
        tick(sd, 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00), NOADDR, "drain0");
        tick(sd, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00), NOADDR, "drain1");
        tick(sd, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00), NOADDR, "done");
`ifdef MAC_ROW_SEQ_PERF_EN
        n_checks++;
        assert (stall_cnt === ((stall_at >= 0 && stall_at < n) ? 16'(stall_len) : 16'h0000)) else begin
            n_err++;
            $error("FAIL stall_cnt: observed %0d expected %0d", stall_cnt,
                   (stall_at >= 0 && stall_at < n) ? stall_len : 0);
        end
`endif
    endtask

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        start     = 1'b0;
        stall     = 1'b0;
        num_steps = 8'h00;
        act_base  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        tick(1'b1, 1'b0, 1'b1, 14'h0000, FULL, "in_reset");
        tick(1'b0, 1'b0, 1'b0, 14'h0000, FULL, "after_reset");

        // Basic 4-step job, then zero-step job, then stalled 3-step job.
        job(8'h10, 4, -1, 0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 14'h0000, FULL, "idle_a");
        job(8'h22, 0, -1, 0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 14'h0000, FULL, "idle_b");
        job(8'h40, 3, 1, 2, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 14'h0000, FULL, "idle_c");

        // Reset during RUN step 2 aborts the job without a done pulse.
        num_steps = 8'd4;
        act_base  = 8'h20;
        tick(1'b1, 1'b0, 1'b0, 14'h0000, FULL, "rst_accept");
        tick(1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h20), FULL, "rst_preload");
        tick(1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20), FULL, "rst_run0");
        tick(1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h20), FULL, "rst_run1");
        tick(1'b0, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h21), FULL, "rst_run2");
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b0, 14'h0000, FULL, "rst_idle");
        end
        job(8'h05, 2, -1, 0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 14'h0000, FULL, "idle_d");

        // Address wrap with start held through busy and DONE; the next IDLE must stay idle.
        job(8'hFF, 4, -1, 0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 14'h0000, FULL, "wrap_ignored_start");

        // Back-to-back jobs with start held continuously.
        job(8'h30, 2, 0, 1, 1'b1);
        job(8'h50, 1, -1, 0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 14'h0000, FULL, "idle_e");

        // Maximum-length job with a stall near the end.
        job(8'hF0, 255, 250, 3, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 14'h0000, FULL, "idle_f");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
